// File: rtl/forward_registered_pipe.sv
// forward_registered_pipe
//   Chain of STAGES forward-registered valid/data slices. Each slice holds
//   valid and payload in flops, so downstream valid/data always come straight
//   from a register. Ready is a combinational chain: an empty slice is always
//   ready, which collapses bubbles even while the sink stalls.
//
//   Parameters: WIDTH  payload width
//               STAGES number of register slices (1..8)
//   Ports:      clk, rst_n            clock, synchronous active-low reset
//               m_valid/m_data/m_ready upstream handshake (block is the sink)
//               s_valid/s_data/s_ready downstream handshake (block is the source)
//               xfer_cnt/stall_cnt    saturating transfer / stall counters,
//                                     present only when FWD_PIPE_STATS_EN is defined
//
//   Note: s_ready -> m_ready is an OR chain STAGES deep by design.

module fwd_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  input  logic             nxt_r,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             r
);
  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    r   = ~v_q | nxt_r;
    v_d = v_q;
    d_d = d_q;
    if (r) v_d = in_v;
    // payload only loads on a real beat so an idle slice keeps its last value
    if (r && in_v) d_d = in_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;
endmodule

module forward_registered_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid,
  input  logic [WIDTH-1:0] m_data,
  output logic             m_ready,
  output logic             s_valid,
  output logic [WIDTH-1:0] s_data,
`ifdef FWD_PIPE_STATS_EN
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      stall_cnt,
`endif
  input  logic             s_ready
);
  logic [STAGES-1:0]            v, r;
  logic [STAGES-1:0][WIDTH-1:0] d;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             in_v, nxt_r;
    logic [WIDTH-1:0] in_d;

    if (i == 0) begin : g_first
      assign in_v = m_valid;
      assign in_d = m_data;
    end else begin : g_mid
      assign in_v = v[i-1];
      assign in_d = d[i-1];
    end

    if (i == STAGES-1) begin : g_last
      assign nxt_r = s_ready;
    end else begin : g_inner
      assign nxt_r = r[i+1];
    end

    fwd_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .in_v  (in_v),
      .in_d  (in_d),
      .nxt_r (nxt_r),
      .v     (v[i]),
      .d     (d[i]),
      .r     (r[i])
    );
  end

  assign m_ready = r[0];
  assign s_valid = v[STAGES-1];
  assign s_data  = d[STAGES-1];

`ifdef FWD_PIPE_STATS_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // both counters stick at all-ones instead of wrapping
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (s_valid && s_ready && !(&xfer_cnt_q))   xfer_cnt_d  = xfer_cnt_q + 32'd1;
    if (s_valid && !s_ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_forward_registered_pipe.sv
// Directed bench for forward_registered_pipe, WIDTH=8, STAGES=2.
module tb_forward_registered_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
`ifdef FWD_PIPE_STATS_EN
  logic [31:0] xfer_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  forward_registered_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .s_valid (s_valid),
    .s_data  (s_data),
`ifdef FWD_PIPE_STATS_EN
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt),
`endif
    .s_ready (s_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset held 3 cycles while a beat is offered
    rst_n = 1'b0; m_valid = 1'b1; m_data = 8'h5A; s_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_s_valid", 32'(s_valid), 32'd0);
      chk("rst_s_data",  32'(s_data),  32'd0);
    end
    rst_n = 1'b1; m_valid = 1'b0;
    #1;
    chk("post_rst_m_ready", 32'(m_ready), 32'd1);
    repeat (3) begin
      tick();
      chk("post_rst_no_5a", 32'(s_valid), 32'd0);
    end

    // 2. streaming 01..10 with s_ready=1
    for (int c = 0; c < 18; c++) begin
      m_valid = (c < 16);
      m_data  = 8'(c + 1);
      #1;
      chk("stream_m_ready", 32'(m_ready), 32'd1);
      tick();
      if (c >= 1 && c <= 16) begin
        chk("stream_s_valid", 32'(s_valid), 32'd1);
        chk("stream_s_data",  32'(s_data),  32'(c));
      end else if (c == 17) begin
        chk("stream_drained", 32'(s_valid), 32'd0);
      end
    end

    // 3. backpressure: A0, A1 accepted, A2 blocked for 3 full cycles
    s_ready = 1'b0;
    m_valid = 1'b1; m_data = 8'hA0; #1;
    chk("bp_acc_a0", 32'(m_ready), 32'd1);
    tick();
    m_data = 8'hA1; #1;
    chk("bp_acc_a1", 32'(m_ready), 32'd1);
    tick();
    m_data = 8'hA2;
    repeat (3) begin
      #1;
      chk("bp_full_m_ready", 32'(m_ready), 32'd0);
      chk("bp_hold_valid",   32'(s_valid), 32'd1);
      chk("bp_hold_data",    32'(s_data),  32'hA0);
      tick();
    end
    s_ready = 1'b1; #1;
    chk("bp_release_m_ready", 32'(m_ready), 32'd1);
    chk("bp_out_a0", 32'(s_data), 32'hA0);
    tick();
    m_valid = 1'b0; #1;
    chk("bp_out_a1_v", 32'(s_valid), 32'd1);
    chk("bp_out_a1",   32'(s_data),  32'hA1);
    tick();
    chk("bp_out_a2_v", 32'(s_valid), 32'd1);
    chk("bp_out_a2",   32'(s_data),  32'hA2);
    tick();
    chk("bp_empty", 32'(s_valid), 32'd0);

    // 4. bubble collapse: 33 stalls at output, 44 still accepted
    s_ready = 1'b0; m_valid = 1'b1; m_data = 8'h33;
    tick();
    m_valid = 1'b0;
    tick();
    chk("bub_33_out_v", 32'(s_valid), 32'd1);
    chk("bub_33_out",   32'(s_data),  32'h33);
    m_valid = 1'b1; m_data = 8'h44; #1;
    chk("bub_m_ready", 32'(m_ready), 32'd1);
    tick();
    m_valid = 1'b0; #1;
    chk("bub_33_stall", 32'(s_data),  32'h33);
    chk("bub_full",     32'(m_ready), 32'd0);
    s_ready = 1'b1;
    tick();
    chk("bub_44_v", 32'(s_valid), 32'd1);
    chk("bub_44",   32'(s_data),  32'h44);
    tick();
    chk("bub_empty", 32'(s_valid), 32'd0);

    // 5. mid-operation reset with 11/22 in flight
    s_ready = 1'b0; m_valid = 1'b1; m_data = 8'h11;
    tick();
    m_data = 8'h22;
    tick();
    m_valid = 1'b0; #1;
    chk("mid_full", 32'(m_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(s_valid), 32'd0);
    chk("mid_rst_data",  32'(s_data),  32'd0);
    rst_n = 1'b1; s_ready = 1'b1; #1;
    chk("mid_rst_m_ready", 32'(m_ready), 32'd1);
    repeat (3) begin
      tick();
      chk("mid_rst_no_beat", 32'(s_valid), 32'd0);
    end

`ifdef FWD_PIPE_STATS_EN
    // 6. counters: 16 transfers, 5 stall cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("stats_rst_xfer",  xfer_cnt,  32'd0);
    chk("stats_rst_stall", stall_cnt, 32'd0);
    m_valid = 1'b1;
    for (int c = 0; c < 23; c++) begin
      m_data  = 8'(c);
      s_ready = !(c == 4 || c == 5 || c == 9 || c == 13 || c == 17);
      if (c >= 2) begin
        #1;
        chk("stats_s_valid", 32'(s_valid), 32'd1);
      end
      tick();
    end
    m_valid = 1'b0;
    chk("stats_xfer",  xfer_cnt,  32'd16);
    chk("stats_stall", stall_cnt, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
